// File: rtl/sweep_line_capture_if.sv
// Sweep-line capture bus: ADC/bear inputs from the decode stage and the line readout handshake.
// The master side drives samples, read address and LineAck; the slave side is the capture block.
interface sweep_line_capture_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
);
    logic              RangeTrace;
    logic              AdcLauch;
    logic [DATA_W-1:0] AdcData;
    logic [11:0]       BearCode;
    logic              BearNorth;
    logic              LineReady;
    logic [11:0]       LineBear;
    logic              LineNorth;
    logic [ADDR_W:0]   LineLen;
    logic [ADDR_W-1:0] RdAddr;
    logic [DATA_W-1:0] RdData;
    logic              LineAck;
    logic [7:0]        Overflow;
    logic [DATA_W-1:0] PeakData;
    logic [ADDR_W-1:0] PeakRange;

    modport master (
        output RangeTrace, AdcLauch, AdcData, BearCode, BearNorth, RdAddr, LineAck,
        input  LineReady, LineBear, LineNorth, LineLen, RdData, Overflow, PeakData, PeakRange
    );

    modport slave (
        input  RangeTrace, AdcLauch, AdcData, BearCode, BearNorth, RdAddr, LineAck,
        output LineReady, LineBear, LineNorth, LineLen, RdData, Overflow, PeakData, PeakRange
    );
endinterface

// File: rtl/sweep_line_capture.sv
// Captures one radar sweep line per RangeTrace window into a two-bank ping-pong RAM with Ready/Ack readout.
// Optional per-line peak tracking is built when LINE_PEAK_EN is defined.
module sweep_line_capture #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                Clk,
    input  logic                nReset,
    sweep_line_capture_if.slave bus
);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned MEM_AW = $clog2(2 * DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_CLOSE, ST_DROP} state_t;
    typedef enum logic [1:0] {BK_EMPTY, BK_FILL, BK_FULL} bank_t;

    state_t            state_q;
    bank_t             bank_q [2];
    logic [11:0]       bear_q [2];
    logic              north_q [2];
    logic [CNT_W-1:0]  len_q [2];
    logic              trace_q, trace_qq;
    logic              pend_q;
    logic              wr_ptr_q, rd_ptr_q, cur_q;
    logic [CNT_W-1:0]  count_q;
    logic [7:0]        ovf_q;
    logic              ready_q;
    logic [11:0]       line_bear_q;
    logic              line_north_q;
    logic [CNT_W-1:0]  line_len_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [2*DEPTH];

    logic              rise_c, fall_c, ack_c, start_req_c, start_c, cap_c, bank_sel_c;
    logic [ADDR_W-1:0] cell_c;
    logic [MEM_AW-1:0] wr_idx_c, rd_idx_c;

    // Edge detect on the registered trace; a strobe in the start cycle lands at cell 0
    assign rise_c      = trace_q & ~trace_qq;
    assign fall_c      = ~trace_q & trace_qq;
    assign ack_c       = bus.LineAck & ready_q;
    assign start_req_c = (state_q == ST_IDLE) & (rise_c | pend_q);
    assign start_c     = start_req_c & (bank_q[wr_ptr_q] == BK_EMPTY);
    assign cap_c       = bus.AdcLauch & (((state_q == ST_CAPTURE) & (count_q < DEPTH_C)) | start_c);
    assign bank_sel_c  = start_c ? wr_ptr_q : cur_q;
    assign cell_c      = start_c ? '0 : count_q[ADDR_W-1:0];
    assign wr_idx_c    = (bank_sel_c ? MEM_AW'(DEPTH) : '0) + MEM_AW'(cell_c);
    assign rd_idx_c    = (rd_ptr_q ? MEM_AW'(DEPTH) : '0) + MEM_AW'(bus.RdAddr);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            bank_q[0]    <= BK_EMPTY;
            bank_q[1]    <= BK_EMPTY;
            bear_q[0]    <= '0;
            bear_q[1]    <= '0;
            north_q[0]   <= 1'b0;
            north_q[1]   <= 1'b0;
            len_q[0]     <= '0;
            len_q[1]     <= '0;
            trace_q      <= 1'b0;
            trace_qq     <= 1'b0;
            pend_q       <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cur_q        <= 1'b0;
            count_q      <= '0;
            ovf_q        <= '0;
            ready_q      <= 1'b0;
            line_bear_q  <= '0;
            line_north_q <= 1'b0;
            line_len_q   <= '0;
        end else begin
            trace_q  <= bus.RangeTrace;
            trace_qq <= trace_q;

            // Consumer release; the freed bank is only seen as EMPTY from the next cycle
            if (ack_c) begin
                bank_q[rd_ptr_q] <= BK_EMPTY;
                rd_ptr_q         <= ~rd_ptr_q;
            end
            ready_q      <= ack_c ? 1'b0 : (bank_q[rd_ptr_q] == BK_FULL);
            line_bear_q  <= bear_q[rd_ptr_q];
            line_north_q <= north_q[rd_ptr_q];
            line_len_q   <= len_q[rd_ptr_q];

            case (state_q)
                ST_IDLE: begin
                    pend_q <= 1'b0;
                    if (start_c) begin
                        bank_q[wr_ptr_q]  <= BK_FILL;
                        bear_q[wr_ptr_q]  <= bus.BearCode;
                        north_q[wr_ptr_q] <= bus.BearNorth;
                        cur_q             <= wr_ptr_q;
                        wr_ptr_q          <= ~wr_ptr_q;
                        count_q           <= CNT_W'(cap_c);
                        state_q           <= ST_CAPTURE;
                    end else if (start_req_c) begin
                        if (ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
                        state_q <= ST_DROP;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.BearNorth) north_q[cur_q] <= 1'b1;
                    if (cap_c) count_q <= count_q + CNT_W'(1);
                    if (fall_c) state_q <= ST_CLOSE;
                end
                ST_CLOSE: begin
                    len_q[cur_q]  <= count_q;
                    bank_q[cur_q] <= BK_FULL;
                    pend_q        <= rise_c;
                    state_q       <= ST_IDLE;
                end
                ST_DROP: begin
                    if (fall_c) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Line RAM: single write port, single registered read port
    always_ff @(posedge Clk) begin
        if (cap_c) mem_q[wr_idx_c] <= bus.AdcData;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) rd_data_q <= '0;
        else         rd_data_q <= mem_q[rd_idx_c];
    end

    assign bus.LineReady = ready_q;
    assign bus.LineBear  = line_bear_q;
    assign bus.LineNorth = line_north_q;
    assign bus.LineLen   = line_len_q;
    assign bus.RdData    = rd_data_q;
    assign bus.Overflow  = ovf_q;

`ifdef LINE_PEAK_EN
    logic [DATA_W-1:0] pk_data_q [2];
    logic [ADDR_W-1:0] pk_range_q [2];
    logic [DATA_W-1:0] out_pk_data_q;
    logic [ADDR_W-1:0] out_pk_range_q;

    // Strictly-greater update keeps the earliest index of the maximum
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pk_data_q[0]   <= '0;
            pk_data_q[1]   <= '0;
            pk_range_q[0]  <= '0;
            pk_range_q[1]  <= '0;
            out_pk_data_q  <= '0;
            out_pk_range_q <= '0;
        end else begin
            if (start_c) begin
                pk_data_q[wr_ptr_q]  <= cap_c ? bus.AdcData : '0;
                pk_range_q[wr_ptr_q] <= '0;
            end else if (cap_c && (bus.AdcData > pk_data_q[cur_q])) begin
                pk_data_q[cur_q]  <= bus.AdcData;
                pk_range_q[cur_q] <= count_q[ADDR_W-1:0];
            end
            out_pk_data_q  <= pk_data_q[rd_ptr_q];
            out_pk_range_q <= pk_range_q[rd_ptr_q];
        end
    end

    assign bus.PeakData  = out_pk_data_q;
    assign bus.PeakRange = out_pk_range_q;
`else
    assign bus.PeakData  = '0;
    assign bus.PeakRange = '0;
`endif

endmodule
